// File: rtl/slice_adder_17_if.sv
// Operand/result bundle between the run controller and slice_adder_17.
// The master drives the start request and operands; the slave returns the result and status.
interface slice_adder_17_if;
  logic        Run;
  logic [15:0] A;
  logic [15:0] B;
  logic [16:0] Sum;
  logic        Load_Out;
  logic        Busy;

  modport master (output Run, A, B, input Sum, Load_Out, Busy);
  modport slave  (input Run, A, B, output Sum, Load_Out, Busy);
endinterface

// File: rtl/slice_adder_17.sv
// Multi-cycle 16-bit adder: SLICE_W bits per clock, 17-bit registered result with a one-cycle
// load strobe for the downstream result register.
module slice_adder_17 #(
  parameter int unsigned SLICE_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  slice_adder_17_if.slave  bus
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SUM_W    = DATA_W + 1;
  localparam int unsigned N_SLICES = DATA_W / SLICE_W;
  localparam int unsigned CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              run_q, run_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] psum_q, psum_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;

  logic [SLICE_W:0]  slice_sum;
  logic [DATA_W-1:0] psum_next;

  // Operands shift right each slice, so the active slice is always the low SLICE_W bits;
  // results enter the partial sum from the top and reach their final position after N slices.
  always_comb begin
    state_d   = state_q;
    run_d     = bus.Run;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    psum_d    = psum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    load_d    = 1'b0;
    busy_d    = busy_q;
    slice_sum = (SLICE_W+1)'(op_a_q[SLICE_W-1:0]) + (SLICE_W+1)'(op_b_q[SLICE_W-1:0])
              + (SLICE_W+1)'(carry_q);
    psum_next = DATA_W'({slice_sum[SLICE_W-1:0], psum_q} >> SLICE_W);

    case (state_q)
      S_IDLE: begin
        if (bus.Run && !run_q) begin
          op_a_d  = bus.A;
          op_b_d  = bus.B;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        op_a_d  = op_a_q >> SLICE_W;
        op_b_d  = op_b_q >> SLICE_W;
        psum_d  = psum_next;
        carry_d = slice_sum[SLICE_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_SLICES - 1)) begin
          sum_d   = {slice_sum[SLICE_W], psum_next};
          load_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // run_q resets high so a Run held through reset is not seen as a rising edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      run_q   <= 1'b1;
      op_a_q  <= '0;
      op_b_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Sum      = sum_q;
  assign bus.Load_Out = load_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_slice_adder_17.sv
// Bench for slice_adder_17: three instances (SLICE_W = 4, 1, 16) share clock, reset and stimulus
// and are compared against an arithmetic model of sum, latency, strobe count and busy length.
module tb_slice_adder_17;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  slice_adder_17_if bus4 ();
  slice_adder_17_if bus1 ();
  slice_adder_17_if bus16 ();

  slice_adder_17 #(.SLICE_W(4))  dut4  (.Clk(Clk), .Reset(Reset), .bus(bus4.slave));
  slice_adder_17 #(.SLICE_W(1))  dut1  (.Clk(Clk), .Reset(Reset), .bus(bus1.slave));
  slice_adder_17 #(.SLICE_W(16)) dut16 (.Clk(Clk), .Reset(Reset), .bus(bus16.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Per-run observations, index 0 = SLICE_W 4, 1 = SLICE_W 1, 2 = SLICE_W 16
  int          lat    [3];
  int          loads  [3];
  int          busy_n [3];
  int          glitch [3];
  logic [16:0] got    [3];
  logic [16:0] last_sum [3];

  function automatic int nc(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  function automatic int sw(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  // {Busy, Load_Out, Sum}
  function automatic logic [18:0] obs(input int i);
    case (i)
      0:       return {bus4.Busy,  bus4.Load_Out,  bus4.Sum};
      1:       return {bus1.Busy,  bus1.Load_Out,  bus1.Sum};
      default: return {bus16.Busy, bus16.Load_Out, bus16.Sum};
    endcase
  endfunction

  task automatic set_run(input logic r);
    bus4.Run = r; bus1.Run = r; bus16.Run = r;
  endtask

  task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b);
    set_run(r);
    bus4.A = a; bus1.A = a; bus16.A = a;
    bus4.B = b; bus1.B = b; bus16.B = b;
  endtask

  // One add from a clean Run rise; hold = sample at which Run drops, rerun = drop/re-raise point,
  // chg = sample at which A is forced to zero.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input int rerun, input int chg);
    int win;
    logic [18:0] o;
    win = hold + rerun + 24;
    set_run(1'b0);
    @(negedge Clk);
    drive(1'b1, a, b);
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1; loads[i] = 0; busy_n[i] = 0; glitch[i] = 0; got[i] = '0;
    end
    for (int k = 1; k <= win; k++) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (o[17]) begin
          loads[i]++;
          if (lat[i] < 0) begin
            lat[i] = k - 1;
            got[i] = o[16:0];
          end
        end else if (lat[i] < 0 && o[16:0] !== last_sum[i]) begin
          glitch[i]++;
        end
        if (o[18]) busy_n[i]++;
      end
      if (k == chg) begin
        bus4.A = 16'h0000; bus1.A = 16'h0000; bus16.A = 16'h0000;
      end
      if (k == hold) set_run(1'b0);
      if (rerun > 0 && k == rerun) set_run(1'b0);
      if (rerun > 0 && k == rerun + 1) set_run(1'b1);
    end
    set_run(1'b0);
  endtask

  task automatic test_reset();
    logic [18:0] o;
    int bad;
    Reset = 1'b0;
    drive(1'b1, 16'hA5A5, 16'h5A5A);
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      n_checks++;
      if (o !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_state w%0d: got %h expected %h", sw(i), o, 19'h0);
      end
    end
    Reset = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (o !== 19'h0) bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL run_held_through_reset: got %0d active samples expected 0", bad);
    end
    for (int i = 0; i < 3; i++) last_sum[i] = '0;
  endtask

  task automatic test_carry_out();
    logic [16:0] exp;
    exp = 17'h0FFFF + 17'h00001;
    do_add(16'hFFFF, 16'h0001, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== exp) begin
        n_fail++; $display("FAIL carry_sum w%0d: got %h expected %h", sw(i), got[i], exp);
      end
      n_checks++;
      if (lat[i] != nc(i)) begin
        n_fail++; $display("FAIL carry_latency w%0d: got %0d expected %0d", sw(i), lat[i], nc(i));
      end
      n_checks++;
      if (loads[i] != 1) begin
        n_fail++; $display("FAIL carry_strobes w%0d: got %0d expected 1", sw(i), loads[i]);
      end
      n_checks++;
      if (busy_n[i] != nc(i) + 1) begin
        n_fail++; $display("FAIL carry_busy w%0d: got %0d expected %0d", sw(i), busy_n[i], nc(i) + 1);
      end
      last_sum[i] = exp;
    end
  endtask

  task automatic test_operand_hold();
    do_add(16'h1234, 16'h4321, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 17'h05555) begin
        n_fail++; $display("FAIL operand_hold w%0d: got %h expected %h", sw(i), got[i], 17'h05555);
      end
      n_checks++;
      if (glitch[i] != 0) begin
        n_fail++; $display("FAIL sum_stable w%0d: got %0d changes expected 0", sw(i), glitch[i]);
      end
      last_sum[i] = 17'h05555;
    end
  endtask

  task automatic test_run_held();
    do_add(16'h8000, 16'h8000, 20, 3, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 17'h10000) begin
        n_fail++; $display("FAIL held_sum w%0d: got %h expected %h", sw(i), got[i], 17'h10000);
      end
      last_sum[i] = 17'h10000;
    end
    // the x16 instance is already idle when Run re-rises, so only the slower ones must ignore it
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (loads[i] != 1) begin
        n_fail++; $display("FAIL held_strobes w%0d: got %0d expected 1", sw(i), loads[i]);
      end
    end
  endtask

  task automatic test_done_ignored();
    logic [16:0] exp;
    exp = 17'h02222 + 17'h01111;
    do_add(16'h2222, 16'h1111, 12, 4, 0);
    n_checks++;
    if (loads[0] != 1 || got[0] !== exp) begin
      n_fail++;
      $display("FAIL done_rise w4: got %0d strobes sum %h expected 1 strobe sum %h", loads[0], got[0], exp);
    end
    for (int i = 0; i < 3; i++) last_sum[i] = exp;
  endtask

  task automatic test_reset_mid_add();
    logic [18:0] o;
    int strobes;
    set_run(1'b0);
    @(negedge Clk);
    drive(1'b1, 16'hFFFF, 16'hFFFF);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = obs(i);
      n_checks++;
      if (o !== 19'h0) begin
        n_fail++; $display("FAIL abort_state w%0d: got %h expected %h", sw(i), o, 19'h0);
      end
      last_sum[i] = '0;
    end
    @(negedge Clk);
    Reset = 1'b1;
    set_run(1'b0);
    strobes = 0;
    repeat (20) begin
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
        o = obs(i);
        if (o[17]) strobes++;
      end
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++; $display("FAIL abort_strobe: got %0d strobes expected 0", strobes);
    end
    do_add(16'hFFFF, 16'hFFFF, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== 17'h1FFFE || lat[i] != nc(i)) begin
        n_fail++;
        $display("FAIL after_abort w%0d: got sum %h lat %0d expected sum %h lat %0d",
                 sw(i), got[i], lat[i], 17'h1FFFE, nc(i));
      end
      last_sum[i] = 17'h1FFFE;
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [16:0] exp;
    int hold;
    for (int t = 0; t < 20; t++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      hold = int'($urandom_range(1, 8));
      exp  = 17'(a) + 17'(b);
      do_add(a, b, hold, 0, 0);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== exp || lat[i] != nc(i) || loads[i] != 1 ||
            busy_n[i] != nc(i) + 1 || glitch[i] != 0) begin
          n_fail++;
          $display("FAIL random w%0d a=%h b=%h: got sum %h lat %0d strobes %0d busy %0d changes %0d expected sum %h lat %0d strobes 1 busy %0d changes 0",
                   sw(i), a, b, got[i], lat[i], loads[i], busy_n[i], glitch[i], exp, nc(i), nc(i) + 1);
        end
        last_sum[i] = exp;
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_out();
    test_operand_hold();
    test_run_held();
    test_done_ignored();
    test_reset_mid_add();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
